// File: rtl/aes_pkg.sv
// Shared AES encipher definitions: key-length codes, round counts, FSM states and
// the GF(2^8) helpers used by the round datapath.
package aes_pkg;

    localparam logic [1:0] KEYLEN_128  = 2'd0;
    localparam logic [1:0] KEYLEN_192  = 2'd1;
    localparam logic [1:0] KEYLEN_256  = 2'd2;
    localparam logic [1:0] KEYLEN_RSVD = 2'd3;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSub,
        StMix,
        StFinal
    } state_e;

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    // Byte 0 of the block is the MSB; column c is 32-bit word c counted from the MSB.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

    function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
        logic [3:0] nr;
        case (keylen)
            KEYLEN_192: nr = NR_192;
            KEYLEN_256: nr = NR_256;
            default:    nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_encipher_iter_if.sv
// Control, key-memory and S-box bus of the iterative AES encipher block.
interface aes_encipher_iter_if #(
    parameter int unsigned SBOX_WORDS = 1
);

    logic                      next;
    logic [1:0]                keylen;
    logic [3:0]                round;
    logic [127:0]              round_key;
    logic [32*SBOX_WORDS-1:0]  sboxw;
    logic [32*SBOX_WORDS-1:0]  new_sboxw;
    logic [127:0]              block;
    logic [127:0]              new_block;
    logic                      ready;
    logic                      error;

    modport master (
        output next, keylen, round_key, new_sboxw, block,
        input  round, sboxw, new_block, ready, error
    );

    modport slave (
        input  next, keylen, round_key, new_sboxw, block,
        output round, sboxw, new_block, ready, error
    );

endinterface

// File: rtl/aes_mixcolumn.sv
// AES MixColumns on a single 32-bit column; byte a0 is the MSB (row 0).
module aes_mixcolumn
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_b0, w_b1, w_b2, w_b3;

    assign w_a0 = i_word[31:24];
    assign w_a1 = i_word[23:16];
    assign w_a2 = i_word[15:8];
    assign w_a3 = i_word[7:0];

    assign w_b0 = gm2(w_a0) ^ gm3(w_a1) ^ w_a2      ^ w_a3;
    assign w_b1 = w_a0      ^ gm2(w_a1) ^ gm3(w_a2) ^ w_a3;
    assign w_b2 = w_a0      ^ w_a1      ^ gm2(w_a2) ^ gm3(w_a3);
    assign w_b3 = gm3(w_a0) ^ w_a1      ^ w_a2      ^ gm2(w_a3);

    assign o_word = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/aes_encipher_iter.sv
// Iterative AES encipher: one round per (4/SBOX_WORDS + 1) cycles. S-boxes and the
// round-key memory are external so they can be shared with the key expansion.
module aes_encipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_WORDS   = 1,
    parameter bit          FINAL_ADDKEY = 1'b1
) (
    input logic                clk,
    input logic                reset,
    aes_encipher_iter_if.slave bus
);

    localparam logic [1:0] SubLast = 2'(4 / SBOX_WORDS - 1);

    state_e           r_fsm;
    logic [0:3][31:0] r_state;
    logic [127:0]     r_new_block;
    logic [3:0]       r_round_ctr;
    logic [3:0]       r_nr;
    logic [1:0]       r_word_ctr;
    logic             r_ready;
    logic             r_error;

    logic [0:3][31:0]          w_shifted;
    logic [0:3][31:0]          w_mixed;
    logic [0:3][31:0]          w_sub_state;
    logic [32*SBOX_WORDS-1:0]  w_sboxw;
    logic [127:0]              w_final_key;
    logic [127:0]              w_final;

    assign w_shifted = shift_rows(r_state);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mixcolumn u_mix (
            .i_word(w_shifted[c]),
            .o_word(w_mixed[c])
        );
    end

    assign w_final_key = FINAL_ADDKEY ? bus.round_key : '0;
    assign w_final     = w_shifted ^ w_final_key;

    // SUB: word group r_word_ctr goes out to the S-boxes and the result is merged back.
    always_comb begin
        w_sboxw     = '0;
        w_sub_state = r_state;
        if (r_fsm == StSub) begin
            for (int unsigned k = 0; k < SBOX_WORDS; k++) begin
                w_sboxw[32*k +: 32] = r_state[2'(32'(r_word_ctr) * SBOX_WORDS + k)];
                w_sub_state[2'(32'(r_word_ctr) * SBOX_WORDS + k)] = bus.new_sboxw[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= StIdle;
            r_state     <= '0;
            r_new_block <= '0;
            r_round_ctr <= '0;
            r_nr        <= '0;
            r_word_ctr  <= '0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_error <= 1'b0;
            unique case (r_fsm)
                StIdle: begin
                    if (bus.next) begin
                        if (bus.keylen == KEYLEN_RSVD) begin
                            r_error <= 1'b1;
                        end else begin
                            r_state     <= bus.block;
                            r_nr        <= num_rounds(bus.keylen);
                            r_ready     <= 1'b0;
                            r_round_ctr <= '0;
                            r_word_ctr  <= '0;
                            r_fsm       <= StInit;
                        end
                    end
                end
                StInit: begin
                    r_state     <= r_state ^ bus.round_key;
                    r_round_ctr <= 4'd1;
                    r_fsm       <= StSub;
                end
                StSub: begin
                    r_state <= w_sub_state;
                    if (r_word_ctr == SubLast) begin
                        r_word_ctr <= '0;
                        r_fsm      <= (r_round_ctr < r_nr) ? StMix : StFinal;
                    end else begin
                        r_word_ctr <= r_word_ctr + 2'd1;
                    end
                end
                StMix: begin
                    r_state     <= w_mixed ^ bus.round_key;
                    r_round_ctr <= r_round_ctr + 4'd1;
                    r_fsm       <= StSub;
                end
                StFinal: begin
                    // Round counter returns to 0 so the key index reads 0 again in IDLE.
                    r_state     <= w_final;
                    r_new_block <= w_final;
                    r_ready     <= 1'b1;
                    r_round_ctr <= '0;
                    r_fsm       <= StIdle;
                end
                default: begin
                    r_fsm <= StIdle;
                end
            endcase
        end
    end

    assign bus.round     = r_round_ctr;
    assign bus.sboxw     = w_sboxw;
    assign bus.new_block = r_new_block;
    assign bus.ready     = r_ready;
    assign bus.error     = r_error;

endmodule
